// File: rtl/shift_cmd_sequencer.sv
// Command sequencer driving a 4-bit universal shift register through a small command FIFO.
// Define SHIFTSEQ_MODEL_EN to add q_model, a shadow copy of the downstream register.
module shift_cmd_sequencer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done
`ifdef SHIFTSEQ_MODEL_EN
  ,
  output logic [WIDTH-1:0] q_model
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FillFull = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  logic [1:0]       r_mem_op   [FIFO_DEPTH];
  logic [WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0] r_mem_cnt  [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_fill;

  state_e           r_state;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_par;
  logic             r_done;

  state_e           w_state_d;
  logic             w_push, w_pop, w_last, w_done_d;
  logic [AW:0]      w_fill_d;
  logic [1:0]       w_head_op;

  assign cmd_ready = (r_fill < FillFull);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head_op = r_mem_op[r_rd_ptr];

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_last    = 1'b0;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_fill != '0) begin
          w_pop     = 1'b1;
          w_state_d = StExec;
        end
      end
      StExec: begin
        // count of 0 or 1 both mean a single cycle; loads always take one
        w_last = (r_op == 2'b11) || (r_rem <= CNT_W'(1));
        if (w_last) begin
          w_done_d = 1'b1;
          if (r_fill != '0) w_pop = 1'b1;
          else              w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_fill_d = r_fill;
    if (w_push && !w_pop)      w_fill_d = r_fill + (AW+1)'(1);
    else if (!w_push && w_pop) w_fill_d = r_fill - (AW+1)'(1);
  end

  // FIFO storage needs no reset: entries are only read below the fill level
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr]   <= cmd_op;
      r_mem_data[r_wr_ptr] <= cmd_data;
      r_mem_cnt[r_wr_ptr]  <= cmd_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_state  <= StIdle;
      r_op     <= 2'b00;
      r_rem    <= '0;
      r_par    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_fill  <= w_fill_d;
      r_state <= w_state_d;
      r_done  <= w_done_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_op     <= w_head_op;
        r_rem    <= r_mem_cnt[r_rd_ptr];
        if (w_head_op == 2'b11) r_par <= r_mem_data[r_rd_ptr];
      end else if (r_state == StExec) begin
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

  assign S       = (r_state == StExec) ? r_op : 2'b00;
  assign par_out = r_par;
  assign busy    = (r_state == StExec) || (r_fill != '0);
  assign done    = r_done;

`ifdef SHIFTSEQ_MODEL_EN
  logic [WIDTH-1:0] r_q_model;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q_model <= '0;
    end else begin
      unique case (S)
        2'b00: r_q_model <= r_q_model;
        2'b01: r_q_model <= {1'b0, r_q_model[WIDTH-1:1]};
        2'b10: r_q_model <= {r_q_model[WIDTH-2:0], 1'b0};
        2'b11: r_q_model <= par_out;
        default: r_q_model <= r_q_model;
      endcase
    end
  end

  assign q_model = r_q_model;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Randomized self-checking bench for shift_cmd_sequencer against a queue-based command model.
module tb_shift_cmd_sequencer;

  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
  } cmd_t;

  logic       clk, reset, cmd_valid, cmd_ready, busy, done;
  logic [1:0] cmd_op, s;
  logic [3:0] cmd_data, par_out, dq;
  logic [2:0] cmd_count;
`ifdef SHIFTSEQ_MODEL_EN
  logic [3:0] q_model;
`endif

  shift_cmd_sequencer #(
    .WIDTH(4),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .cmd_count(cmd_count),
    .S(s),
    .par_out(par_out),
    .busy(busy),
    .done(done)
`ifdef SHIFTSEQ_MODEL_EN
    ,
    .q_model(q_model)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream shift register (active-high reset, driven by inverted reset)
  always_ff @(posedge clk) begin
    if (!reset) dq <= 4'b0;
    else begin
      case (s)
        2'b01:   dq <= {1'b0, dq[3:1]};
        2'b10:   dq <= {dq[2:0], 1'b0};
        2'b11:   dq <= par_out;
        default: dq <= dq;
      endcase
    end
  end

  int checks = 0, failures = 0;
  cmd_t m_q[$];
  bit   m_act = 0, m_done = 0;
  logic [1:0] m_op = 2'b00;
  int   m_left = 0;
  logic [3:0] m_par = 4'b0, m_qm = 4'b0;
  int   m_done_cnt = 0, dut_done_cnt = 0;
  logic [3:0] done_log[$];
  bit   saw_not_ready = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model across one rising edge using current inputs.
  task automatic model_step();
    bit acc, pop;
    logic [1:0] s_now;
    cmd_t c;
    if (!reset) begin
      m_q.delete();
      m_act = 0; m_done = 0; m_op = 2'b00; m_left = 0; m_par = 4'b0; m_qm = 4'b0;
      return;
    end
    acc   = cmd_valid && (m_q.size() < FIFO_DEPTH);
    s_now = m_act ? m_op : 2'b00;
    case (s_now)
      2'b01:   m_qm = m_qm >> 1;
      2'b10:   m_qm = m_qm << 1;
      2'b11:   m_qm = m_par;
      default: m_qm = m_qm;
    endcase
    m_done = m_act && (m_left == 1);
    if (m_done) m_done_cnt++;
    pop = (!m_act || m_left == 1) && (m_q.size() > 0);
    if (m_act) begin
      m_left--;
      if (m_left == 0) m_act = 0;
    end
    if (pop) begin
      c      = m_q.pop_front();
      m_act  = 1;
      m_op   = c.op;
      m_left = (c.op == 2'b11 || c.cnt == 3'd0) ? 1 : int'(c.cnt);
      if (c.op == 2'b11) m_par = c.data;
    end
    if (acc) m_q.push_back('{op: cmd_op, data: cmd_data, cnt: cmd_count});
  endtask

  task automatic compare_outputs();
    check_eq("S", s, m_act ? m_op : 2'b00);
    check_eq("par_out", par_out, m_par);
    check_eq("busy", busy, m_act || (m_q.size() != 0));
    check_eq("cmd_ready", cmd_ready, m_q.size() < FIFO_DEPTH);
    check_eq("done", done, m_done);
    check_eq("q_downstream", dq, m_qm);
`ifdef SHIFTSEQ_MODEL_EN
    check_eq("q_model", q_model, m_qm);
`endif
    if (done === 1'b1) begin
      dut_done_cnt++;
      done_log.push_back(dq);
    end
    if (cmd_ready === 1'b0) saw_not_ready = 1;
  endtask

  task automatic tick();
    compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] d, input logic [2:0] c);
    int n = 0;
    bit acc;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c;
    do begin
      acc = reset && (m_q.size() < FIFO_DEPTH);
      tick();
      n++;
    end while (!acc && n < 200);
    check_eq("push_accepted", acc, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_act || m_q.size() != 0 || m_done) && n < 500) begin
      tick();
      n++;
    end
    check_eq("idle_within_bound", n < 500, 1);
    tick();
  endtask

  int base, dbase;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'b0; cmd_count = 3'b0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b1;
    tick();

    // Load then shift-left twice, back to back
    base = done_log.size();
    push(2'b11, 4'b1011, 3'd0);
    push(2'b10, 4'b0000, 3'd2);
    wait_idle();
    check_eq("t2_done_count", done_log.size(), base + 2);
    check_eq("t2_q_after_load", done_log[base], 4'b1011);
    check_eq("t2_q_after_shl", done_log[base+1], 4'b1100);

    // Shift-right with count 0 runs exactly once
    base = done_log.size();
    push(2'b11, 4'b1000, 3'd0);
    push(2'b01, 4'b0000, 3'd0);
    wait_idle();
    check_eq("t3_done_count", done_log.size(), base + 2);
    check_eq("t3_q_after_shr", done_log[base+1], 4'b0100);

    // Reset held for 3 cycles in the middle of a long hold
    push(2'b00, 4'b0000, 3'd7);
    push(2'b11, 4'b0110, 3'd0);
    repeat (2) tick();
    dbase = dut_done_cnt;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_S", s, 2'b00);
    check_eq("rst_par_out", par_out, 4'b0);
    repeat (4) tick();
    check_eq("rst_no_done", dut_done_cnt, dbase);

    // Overfill the FIFO behind a slow hold
    base = done_log.size();
    saw_not_ready = 0;
    push(2'b00, 4'b0000, 3'd7);
    for (int i = 1; i <= 5; i++) push(2'b11, 4'(i), 3'd0);
    wait_idle();
    check_eq("t4_ready_dropped", saw_not_ready, 1);
    check_eq("t4_done_count", done_log.size(), base + 6);
    for (int i = 1; i <= 5; i++) check_eq("t4_order", done_log[base+i], 4'(i));

    // Push coinciding with pop while two entries wait
    base = done_log.size();
    push(2'b00, 4'b0000, 3'd3);
    push(2'b11, 4'b0001, 3'd0);
    push(2'b10, 4'b0000, 3'd1);
    tick();
    push(2'b11, 4'b1111, 3'd0);
    wait_idle();
    check_eq("t5_done_count", done_log.size(), base + 4);
    check_eq("t5_second", done_log[base+1], 4'b0001);
    check_eq("t5_third", done_log[base+2], 4'b0010);
    check_eq("t5_last", done_log[base+3], 4'b1111);

    // Random command stream
    dbase = dut_done_cnt;
    for (int i = 0; i < 50; i++) begin
      push(2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end
    wait_idle();
    check_eq("rand_done_count", dut_done_cnt - dbase, 50);
    check_eq("total_done", dut_done_cnt, m_done_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
